serial_word_deser: RTL and testbench
====================================

Name: serial_word_deser

Overview:
- Downstream stage of the bit-serial two's-complement unit.
- Collects its LSB-first serial output (one bit per clk, fixed WIDTH-bit frames aligned to reset) into parallel words.
- Buffers completed words in a 2-entry FIFO and presents them on a valid/ready interface to the consumer.
- Drops words on overflow and flags the overflow.

Parameters:
- WIDTH, 4, bits per serial frame (must match the upstream frame length).
- DEPTH, 2, output FIFO entries (fixed at 2; the parameter exists for the package constant only).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset; clears all state.
- sin  input  1  serial data bit, LSB of each word first.
- in_en  input  1  bit-valid qualifier; tie high when fed by the free-running upstream stage.
- dout  output  WIDTH  head-of-FIFO word.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts dout this cycle.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
Clock and reset:
- One clock: clk.
- Reset is asynchronous, active-low (reset_n).
- Reset values: bit_cnt=0, shift reg=0, FIFO empty, dout=0, dout_valid=0, ovf=0.

Framing:
- bit_cnt runs 0..WIDTH-1 and advances only when in_en=1.
- It wraps to 0 after WIDTH-1.
- in_en=0 holds bit_cnt and the shift register; the bit is ignored.
- Frame alignment: the first in_en=1 cycle after reset release is bit 0. This matches the upstream 4-cycle counter, which is released by the same reset_n.

Shift:
- On in_en=1: sr <= {sin, sr[WIDTH-1:1]}.
- The bit sampled at bit_cnt=i ends up at word position i.

Word completion:
- Completion is the cycle with in_en=1 and bit_cnt=WIDTH-1.
- The word pushed is {sin, sr[WIDTH-1:1]}.
- sr is not cleared; it is fully overwritten by the next frame.

FIFO:
- 2 entries, registered.
- dout = head entry, dout_valid = (count != 0).
- Pop when dout_valid && dout_ready.
- Latency: a word appears on dout with dout_valid=1 on the clock edge that samples its last bit, i.e. visible in the cycle after the last bit is presented.
- dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
- dout_ready while empty: no effect.

Simultaneous push and pop:
- Empty: push only.
- Count=1: count stays 1, and the new word becomes head next cycle.
- Full (count=2): the pop frees a slot, the push succeeds, count stays 2, and ovf is not set.

Overflow:
- Push while full with no pop: the new word is dropped, FIFO contents are unchanged, and ovf is set.
- ovf stays set until ovf_clr=1 or reset.
- ovf_clr and a new overflow in the same cycle: ovf=1 (set wins).

Reset mid-frame:
- The partial word is discarded, bit_cnt returns to 0 and the FIFO is emptied.
- There is no partial push.

Optional Feature:
- Macro: SERIAL_DESER_DROPCNT_EN.
- Defined:
  - Adds output drop_cnt [7:0], reset 0.
  - drop_cnt increments on every dropped word and saturates at 8'hFF.
  - ovf_clr also clears drop_cnt.
  - If ovf_clr and a drop occur in the same cycle, drop_cnt=1.
- Undefined: no drop_cnt port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package (serial_pkg) holds:
  - WORD_W=4 and FIFO_DEPTH=2.
  - CNT_W = clog2(WORD_W).
  - The bit-counter type. This is the same frame constant the two's-complement stage and any upstream serializer use.
- One sub-module: word_fifo2. It is a 2-entry synchronous FIFO with push/pop, full/empty and head output, using the same clock and reset.
- Framing, shift register and overflow logic stay in serial_word_deser.

Test Plan:
1. Basic word: after reset, in_en=1, dout_ready=1, sin=1,0,1,1 (upstream two's complement of 4'h3) -> after the 4th edge, dout=4'hD and dout_valid=1 for exactly one cycle; ovf=0.
2. Back-to-back stream: sin frames for 4'h1, 4'hF, 4'h8 with continuous in_en and dout_ready=1 -> dout_valid pulses every 4th cycle with dout=1, F, 8 in order.
3. Backpressure/overflow: dout_ready=0 across 3 frames (4'h2, 4'h5, 4'hA) -> dout=4'h2 held, 2 entries, ovf=1 after the 3rd frame. Then ready=1 -> outputs 2 then 5, and 4'hA never appears. ovf_clr pulse -> ovf=0.
4. Full with simultaneous pop: FIFO full (4'h2, 4'h5) and dout_ready=1 exactly in the cycle the 3rd word (4'h7) completes -> 2, 5, 7 delivered in order; ovf stays 0.
5. Stall and reset: in_en=0 for 3 cycles between bits 1 and 2 of 4'hC -> still 4'hC. Then assert reset_n=0 after 2 bits of the next frame -> dout_valid=0 and the FIFO is empty. After release, frame 4'h6 -> dout=4'h6.
6. SERIAL_DESER_DROPCNT_EN build: force 300 dropped words -> drop_cnt=8'hFF (saturated). Then ovf_clr -> drop_cnt=0 and ovf=0.

Source files
------------

// File: rtl/serial_pkg.sv
// ============================================================================
// serial_pkg : frame constants and bit-counter type shared by the serial chain
// Revision   : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;
    localparam int WORD_W     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(WORD_W);

    typedef logic [CNT_W-1:0] bit_cnt_t;
endpackage

`default_nettype wire

// File: rtl/word_fifo2.sv
// ============================================================================
// word_fifo2 : 2-entry registered synchronous FIFO with head-of-queue output
// Revision   : 1.0
// ============================================================================
`default_nettype none

module word_fifo2
    import serial_pkg::*;
#(
    parameter int W     = WORD_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_count;
    logic [W-1:0]  r_head;
    logic [W-1:0]  r_tail;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = r_head;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_count <= r_count + CW'(1);
                    if (o_empty) r_head <= i_din;
                    else         r_tail <= i_din;
                end
                2'b01: begin
                    r_count <= r_count - CW'(1);
                    r_head  <= r_tail;
                end
                2'b11: begin
                    if (r_count == CW'(1)) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/serial_word_deser.sv
// ============================================================================
// serial_word_deser : LSB-first serial-to-word collector with 2-entry output
//                     FIFO and sticky overflow; SERIAL_DESER_DROPCNT_EN adds a
//                     saturating dropped-word counter (drop_cnt).
// Revision          : 1.0
// ============================================================================
`default_nettype none

module serial_word_deser
    import serial_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sin,
    input  logic             in_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             ovf,
`ifdef SERIAL_DESER_DROPCNT_EN
    output logic [7:0]       drop_cnt,
`endif
    input  logic             ovf_clr
);
    localparam bit_cnt_t c_LAST = bit_cnt_t'(WIDTH - 1);

    bit_cnt_t         r_bit_cnt;
    // Only the upper WIDTH-1 bits of the shift register ever reach a word;
    // the oldest bit falls off at completion, so it is not stored.
    logic [WIDTH-2:0] r_sr;
    logic             r_ovf;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;

    assign w_word = {sin, r_sr};
    assign w_done = in_en && (r_bit_cnt == c_LAST);
    assign w_drop = w_done && w_full && !dout_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_sr      <= '0;
        end else if (in_en) begin
            r_bit_cnt <= (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + bit_cnt_t'(1);
            r_sr      <= w_word[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_ovf <= 1'b0;
        else if (w_drop)  r_ovf <= 1'b1;
        else if (ovf_clr) r_ovf <= 1'b0;
    end

`ifdef SERIAL_DESER_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_drop_cnt <= 8'h00;
        else if (ovf_clr)
            r_drop_cnt <= w_drop ? 8'h01 : 8'h00;
        else if (w_drop && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'h01;
    end

    assign drop_cnt = r_drop_cnt;
`endif

    word_fifo2 #(
        .W     (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_done),
        .i_pop   (dout_ready),
        .i_din   (w_word),
        .o_head  (dout),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign dout_valid = !w_empty;
    assign ovf        = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_serial_word_deser.sv
// ============================================================================
// tb_serial_word_deser : directed and random checks of serial_word_deser
//                        against a queue-based model of the word stream.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_serial_word_deser;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sin = 1'b0;
    logic       in_en = 1'b0;
    logic       dout_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic       ovf;
`ifdef SERIAL_DESER_DROPCNT_EN
    logic [7:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model: bits of the frame in progress, queued words, sticky flags.
    int         m_bits[$];
    logic [3:0] m_q[$];
    logic       m_ovf;
    int         m_drops;

    serial_word_deser dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sin        (sin),
        .in_en      (in_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovf        (ovf),
`ifdef SERIAL_DESER_DROPCNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", {31'd0, dout_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) chk("dout", {28'd0, dout}, {28'd0, m_q[0]});
        chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`ifdef SERIAL_DESER_DROPCNT_EN
        chk("drop_cnt", {24'd0, drop_cnt}, (m_drops > 255) ? 32'd255 : 32'(m_drops));
`endif
    endtask

    // Called at a negedge: apply inputs, advance the model, check after the edge.
    task automatic cycle(input logic s, input logic en, input logic rdy, input logic clr);
        logic       push;
        logic       drop;
        logic [3:0] w;
        sin = s; in_en = en; dout_ready = rdy; ovf_clr = clr;
        push = 1'b0;
        drop = 1'b0;
        w    = '0;
        if (en) begin
            m_bits.push_back(int'(s));
            if (m_bits.size() == 4) begin
                for (int i = 0; i < 4; i++) w[i] = m_bits[i][0];
                m_bits.delete();
                push = 1'b1;
            end
        end
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(w);
            else drop = 1'b1;
        end
        if (clr) m_drops = drop ? 1 : 0;
        else if (drop) m_drops++;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic send_word(input logic [3:0] w, input logic rdy);
        for (int i = 0; i < 4; i++) cycle(w[i], 1'b1, rdy, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sin = 1'b0; in_en = 1'b0; dout_ready = 1'b0; ovf_clr = 1'b0;
        m_bits.delete();
        m_q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        #1;
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout", {28'd0, dout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // 1: single word, two's complement of 3 arrives as 1,0,1,1
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1_valid", {31'd0, dout_valid}, 32'd1);
        chk("t1_dout", {28'd0, dout}, 32'hD);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_pulse", {31'd0, dout_valid}, 32'd0);

        // 2: back-to-back frames with a free-flowing consumer
        send_word(4'h1, 1'b1);
        chk("t2_w0", {28'd0, dout}, 32'h1);
        send_word(4'hF, 1'b1);
        chk("t2_w1", {28'd0, dout}, 32'hF);
        send_word(4'h8, 1'b1);
        chk("t2_w2", {28'd0, dout}, 32'h8);

        // 3: backpressure, third word dropped
        do_reset();
        send_word(4'h2, 1'b0);
        send_word(4'h5, 1'b0);
        send_word(4'hA, 1'b0);
        chk("t3_head", {28'd0, dout}, 32'h2);
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_second", {28'd0, dout}, 32'h5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_empty", {31'd0, dout_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr", {31'd0, ovf}, 32'd0);

        // 4: full FIFO, pop in the completion cycle of the third word
        do_reset();
        send_word(4'h2, 1'b0);
        send_word(4'h5, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_head", {28'd0, dout}, 32'h5);
        chk("t4_ovf", {31'd0, ovf}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_last", {28'd0, dout}, 32'h7);

        // 5: in_en stall inside a frame, then reset mid-frame
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_stall", {28'd0, dout}, 32'hC);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        chk("t5_rst_empty", {31'd0, dout_valid}, 32'd0);
        send_word(4'h6, 1'b0);
        chk("t5_after", {28'd0, dout}, 32'h6);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

`ifdef SERIAL_DESER_DROPCNT_EN
        // 6: saturate the drop counter
        do_reset();
        send_word(4'h3, 1'b0);
        send_word(4'h4, 1'b0);
        for (int n = 0; n < 300; n++) send_word(4'(n), 1'b0);
        chk("t6_sat", {24'd0, drop_cnt}, 32'hFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_clr_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("t6_clr_ovf", {31'd0, ovf}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
